sb_adapter_cfg_endpoint: RTL

Adapter-side endpoint of the RDI sideband configuration interface: the far end of the PHY's lp_cfg/pl_cfg path. It serializes 64-bit sideband messages from the adapter core into two 32-bit lp_cfg beats under PHY-granted credits, and reassembles 32-bit pl_cfg beats into 64-bit messages buffered for the adapter core. It returns one lp_cfg_crd pulse per message the core drains. It sits between the adapter's sideband message logic and the PHY's RDI sideband wrapper.

---
 rtl/sb_adapter_cfg_endpoint.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sb_adapter_cfg_endpoint.sv
// sb_adapter_cfg_endpoint: adapter-side RDI sideband cfg endpoint (TX serializer, RX reassembler and buffer)
module sb_adapter_cfg_endpoint #(
   parameter int CRD_INIT = 4,
   parameter int RX_DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_tx_valid,
   input  logic [63:0] i_tx_msg,
   output logic        o_tx_ready,
   output logic        o_lp_cfg_vld,
   output logic [31:0] o_lp_cfg,
   input  logic        i_pl_cfg_crd,
   input  logic        i_pl_cfg_vld,
   input  logic [31:0] i_pl_cfg,
   output logic        o_lp_cfg_crd,
   output logic        o_rx_valid,
   output logic [63:0] o_rx_msg,
   input  logic        i_rx_ready,
   output logic [3:0]  o_crd_count,
   output logic [2:0]  o_err
);
   localparam int AW = $clog2(RX_DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;
   localparam logic [3:0] CRD_MAX = 4'(CRD_INIT);

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

   state_t      state;
   logic [31:0] msg_hi;
   logic [3:0]  crd_count;
   logic        phase;
   logic [31:0] rx_lo;
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [63:0] mem [RX_DEPTH];
   logic [2:0]  err;
   logic        accept;
   logic        pop;
   logic        push;
   logic        push_ok;
   logic        full;

   assign o_tx_ready  = (state == IDLE || state == BEAT1) && crd_count != 4'd0;
   assign accept      = i_tx_valid && o_tx_ready;
   assign o_crd_count = crd_count;
   assign o_err       = err;
   assign o_rx_valid  = wr_ptr != rd_ptr;
   assign o_rx_msg    = mem[rd_ptr[AW-1:0]];
   assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop         = o_rx_valid && i_rx_ready;
   assign push        = i_pl_cfg_vld && phase;
   assign push_ok     = push && (!full || pop);

   // TX serializer: the state names the beat currently on lp_cfg, so outputs are registered
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= IDLE;
         o_lp_cfg_vld <= 1'b0;
         o_lp_cfg     <= '0;
         msg_hi       <= '0;
      end else if (accept) begin
         state        <= BEAT0;
         o_lp_cfg_vld <= 1'b1;
         o_lp_cfg     <= i_tx_msg[31:0];
         msg_hi       <= i_tx_msg[63:32];
      end else if (state == BEAT0) begin
         state        <= BEAT1;
         o_lp_cfg     <= msg_hi;
      end else begin
         state        <= IDLE;
         o_lp_cfg_vld <= 1'b0;
      end
   end

   // TX credit counter: a simultaneous accept and returned credit cancel out; saturates at CRD_INIT
   always_ff @(posedge i_clk) begin
      if (i_rst)
         crd_count <= CRD_MAX;
      else if (accept && !i_pl_cfg_crd)
         crd_count <= crd_count - 4'd1;
      else if (!accept && i_pl_cfg_crd && crd_count != CRD_MAX)
         crd_count <= crd_count + 4'd1;
   end

   // Sticky errors: credit overflow, RX buffer overflow, beat pair broken by an idle cycle
   always_ff @(posedge i_clk) begin
      if (i_rst)
         err <= '0;
      else
         err <= err | {!i_pl_cfg_vld && phase, push && !push_ok, i_pl_cfg_crd && !accept && crd_count == CRD_MAX};
   end

   // RX assembler: first beat of a pair is held as the low word; a gap discards it
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         phase <= 1'b0;
         rx_lo <= '0;
      end else if (i_pl_cfg_vld && !phase) begin
         phase <= 1'b1;
         rx_lo <= i_pl_cfg;
      end else begin
         phase <= 1'b0;
      end
   end

   // RX buffer pointers and the credit pulse returned one cycle after each pop
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         o_lp_cfg_crd <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         o_lp_cfg_crd <= pop;
      end
   end

   // RX buffer storage; entry 0 is cleared so the show-ahead head reads zero after reset
   always_ff @(posedge i_clk) begin
      if (i_rst)
         mem[0] <= '0;
      else if (push_ok)
         mem[wr_ptr[AW-1:0]] <= {i_pl_cfg, rx_lo};
   end
endmodule
